// File: rtl/imem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : imem_pkg
//  Description : Shared opcodes and the fetch-sequencer state encoding used by
//                imem_fetch_ctrl and its output stage.
//  Revision    : 1.0 - initial release
// ============================================================================
package imem_pkg;

    // RV32I encodings the fetch unit must recognise or reset to
    localparam logic [31:0] OPC_EBREAK = 32'h0010_0073;
    localparam logic [31:0] OPC_NOP    = 32'h0000_0013;

    // Fetch sequencer states (3-bit encoding)
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RUN   = 3'd1,
        ST_DRAIN = 3'd2,
        ST_HALT  = 3'd3,
        ST_FAULT = 3'd4
    } fetch_state_t;

endpackage : imem_pkg
`default_nettype wire

// File: rtl/if_out_reg.sv
`default_nettype none
// ============================================================================
//  Module      : if_out_reg
//  Description : One-entry instruction output register toward decode.
//                Holds {instr, pc} with a valid flag. The owner decides when
//                to capture, flush or retire the entry.
//  Ports       : clk, rst       - clock, synchronous active-high reset
//                i_capture      - load i_instr/i_pc and set valid
//                i_flush        - drop the entry (redirect / fault)
//                i_clear        - entry accepted with nothing to replace it
//                i_instr, i_pc  - data to capture
//                o_valid, o_instr, o_pc - registered entry
//  Revision    : 1.0 - initial release
// ============================================================================
module if_out_reg
    import imem_pkg::*;
(
    input  wire logic        clk,
    input  wire logic        rst,
    input  wire logic        i_capture,
    input  wire logic        i_flush,
    input  wire logic        i_clear,
    input  wire logic [31:0] i_instr,
    input  wire logic [31:0] i_pc,
    output logic             o_valid,
    output logic [31:0]      o_instr,
    output logic [31:0]      o_pc
);

    logic        r_valid;
    logic [31:0] r_instr;
    logic [31:0] r_pc;

    // Flush outranks capture so a redirect always leaves a bubble, even if
    // the controller happened to assert both.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_instr <= OPC_NOP;
            r_pc    <= 32'h0000_0000;
        end else if (i_flush) begin
            r_valid <= 1'b0;
        end else if (i_capture) begin
            r_valid <= 1'b1;
            r_instr <= i_instr;
            r_pc    <= i_pc;
        end else if (i_clear) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_instr = r_instr;
    assign o_pc    = r_pc;

endmodule : if_out_reg
`default_nettype wire

// File: rtl/imem_fetch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : imem_fetch_ctrl
//  Description : Instruction fetch sequencer for a single-cycle-read
//                instruction memory. Owns the PC, registers each fetched word
//                into a one-entry valid/ready stage, follows branch redirects,
//                stops after EBREAK and traps misaligned/out-of-range fetches.
//  Ports       : clk, rst                 - clock, synchronous active-high reset
//                start                    - begin/resume (IDLE, HALT only)
//                imem_addr / imem_rdata   - memory address / combinational data
//                if_valid/if_ready/if_instr/if_pc - decode handshake
//                redirect_valid/redirect_pc       - taken branch from execute
//                halted, fault            - status (fault sticky until rst)
//  Revision    : 1.0 - initial release
// ============================================================================
module imem_fetch_ctrl
    import imem_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          MEM_WORDS = 256
) (
    input  wire logic        clk,
    input  wire logic        rst,
    input  wire logic        start,
    output logic [31:0]      imem_addr,
    input  wire logic [31:0] imem_rdata,
    output logic             if_valid,
    input  wire logic        if_ready,
    output logic [31:0]      if_instr,
    output logic [31:0]      if_pc,
    input  wire logic        redirect_valid,
    input  wire logic [31:0] redirect_pc,
    output logic             halted,
    output logic             fault
);

    // Byte limit held in 33 bits so MEM_WORDS*4 cannot overflow the compare
    localparam logic [32:0] c_MEM_LIMIT = 33'(MEM_WORDS) * 33'd4;

    fetch_state_t r_state;
    fetch_state_t w_state_nxt;
    logic [31:0]  r_pc;
    logic [31:0]  w_pc_nxt;

    logic w_load;
    logic w_out_of_range;
    logic w_redir_misaligned;
    logic w_capture;
    logic w_flush;
    logic w_clear;
    logic w_valid;

    // The stage can take a new word when empty or being drained this cycle
    assign w_load             = !w_valid || if_ready;
    assign w_out_of_range     = ({1'b0, r_pc} >= c_MEM_LIMIT);
    assign w_redir_misaligned = (redirect_pc[1:0] != 2'b00);

    // ------------------------------------------------------------------
    // State and PC registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_pc    <= RESET_PC;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state, next-PC and output-stage control
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_capture   = 1'b0;
        w_flush     = 1'b0;
        w_clear     = 1'b0;

        unique case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt = ST_RUN;
                end
            end

            ST_RUN: begin
                if (redirect_valid) begin
                    // Flush regardless of a same-cycle accept; the accept
                    // still completes on the decode side.
                    w_flush = 1'b1;
                    if (w_redir_misaligned) begin
                        w_state_nxt = ST_FAULT;
                    end else begin
                        w_pc_nxt = redirect_pc;
                    end
                end else if (w_load && w_out_of_range) begin
                    w_flush     = 1'b1;
                    w_state_nxt = ST_FAULT;
                end else if (w_load) begin
                    w_capture = 1'b1;
                    w_pc_nxt  = r_pc + 32'd4;
                    if (imem_rdata == OPC_EBREAK) begin
                        w_state_nxt = ST_DRAIN;
                    end
                end
            end

            ST_DRAIN: begin
                // An older branch still in execute squashes the ebreak
                if (redirect_valid) begin
                    w_flush = 1'b1;
                    if (w_redir_misaligned) begin
                        w_state_nxt = ST_FAULT;
                    end else begin
                        w_pc_nxt    = redirect_pc;
                        w_state_nxt = ST_RUN;
                    end
                end else if (w_valid && if_ready) begin
                    w_clear     = 1'b1;
                    w_state_nxt = ST_HALT;
                end
            end

            ST_HALT: begin
                if (start) begin
                    w_state_nxt = ST_RUN;
                end
            end

            ST_FAULT: begin
                w_state_nxt = ST_FAULT;
            end

            default: begin
                w_state_nxt = ST_FAULT;
                w_flush     = 1'b1;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output stage
    // ------------------------------------------------------------------
    if_out_reg u_if_out_reg (
        .clk       (clk),
        .rst       (rst),
        .i_capture (w_capture),
        .i_flush   (w_flush),
        .i_clear   (w_clear),
        .i_instr   (imem_rdata),
        .i_pc      (r_pc),
        .o_valid   (w_valid),
        .o_instr   (if_instr),
        .o_pc      (if_pc)
    );

    assign imem_addr = r_pc;
    assign if_valid  = w_valid;
    assign halted    = (r_state == ST_HALT);
    assign fault     = (r_state == ST_FAULT);

endmodule : imem_fetch_ctrl
`default_nettype wire
